// File: rtl/i2c_target_regs_pkg.sv
// Shared I2C definitions: FSM state encoding and byte/synchronizer sizing.
package i2c_pkg;

    localparam int I2C_BYTE_W  = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA pin synchronizers with idle-high reset, plus SCL edge and START/STOP detection.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SDA edges only count as START/STOP while SCL stayed high across both samples
    assign start_det = scl_s & scl_d & sda_d & ~sda;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target that bridges write/read transfers onto a local register-bus master port.
//
// state     | meaning
// IDLE      | waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | acknowledging our address; first read strobe when R/W=1
// PTR       | shifting in register pointer
// PTR_ACK   | acknowledging pointer
// WDATA     | shifting in write data, strobing reg_wr_en on the 8th bit
// WDATA_ACK | acknowledging write data
// RDATA     | driving read data MSB first
// RDATA_ACK | sampling master ACK/NACK
// IGNORE    | not addressed or read ended; waiting for START/STOP
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int          REG_AW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [REG_AW-1:0]     reg_addr,
    output logic [I2C_BYTE_W-1:0] reg_wdata,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);

    localparam logic [REG_AW-1:0] ADDR_ONE = REG_AW'(1);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e              state, state_nxt;
    logic [2:0]              bit_cnt, bit_cnt_nxt;
    logic [I2C_BYTE_W-2:0]   rx_sr, rx_nxt;
    logic [I2C_BYTE_W-1:0]   rx_byte;
    logic [I2C_BYTE_W-1:0]   tx_sr, tx_nxt;
    logic                    rw, rw_nxt;
    logic                    rd_dly;
    logic                    sda_oe_nxt, busy_nxt, wr_en_nxt, rd_en_nxt;
    logic [REG_AW-1:0]       addr_nxt;
    logic [I2C_BYTE_W-1:0]   wdata_nxt;
    logic                    addr_match;

    assign rx_byte    = {rx_sr, sda};
    assign addr_match = (rx_byte[7:1] == TARGET_ADDR) && (rx_byte[7:1] != 7'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rw        <= 1'b0;
            rd_dly    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_sr     <= rx_nxt;
            tx_sr     <= tx_nxt;
            rw        <= rw_nxt;
            rd_dly    <= reg_rd_en;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            reg_wr_en <= wr_en_nxt;
            reg_rd_en <= rd_en_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = rx_sr;
        // read data arrives one clk after the strobe, well before the next SCL fall
        tx_nxt      = rd_dly ? reg_rdata : tx_sr;
        rw_nxt      = rw;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        addr_nxt    = reg_wr_en ? reg_addr + ADDR_ONE : reg_addr;
        wdata_nxt   = reg_wdata;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;

        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        rx_nxt      = rx_byte[I2C_BYTE_W-2:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt = '0;
                            if (state == ADDR) begin
                                rw_nxt = rx_byte[0];
                                if (addr_match) begin
                                    state_nxt = ADDR_ACK;
                                    busy_nxt  = 1'b1;
                                end else begin
                                    state_nxt = IGNORE;
                                    busy_nxt  = 1'b0;
                                end
                            end else if (state == PTR) begin
                                addr_nxt  = REG_AW'(rx_byte);
                                state_nxt = PTR_ACK;
                            end else begin
                                wr_en_nxt = 1'b1;
                                wdata_nxt = rx_byte;
                                state_nxt = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall && bit_cnt == 3'd0) begin
                        sda_oe_nxt  = 1'b1;
                        bit_cnt_nxt = 3'd1;
                    end else if (scl_rise && bit_cnt == 3'd1) begin
                        bit_cnt_nxt = 3'd2;
                        rd_en_nxt   = (state == ADDR_ACK) && rw;
                    end else if (scl_fall && bit_cnt == 3'd2) begin
                        bit_cnt_nxt = '0;
                        if (state == ADDR_ACK && rw) begin
                            sda_oe_nxt = ~tx_sr[I2C_BYTE_W-1];
                            tx_nxt     = {tx_sr[I2C_BYTE_W-2:0], 1'b0};
                            state_nxt  = RDATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = (state == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_nxt = ~tx_sr[I2C_BYTE_W-1];
                        tx_nxt     = {tx_sr[I2C_BYTE_W-2:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall && bit_cnt == 3'd0) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd1;
                    end else if (scl_rise && bit_cnt == 3'd1) begin
                        // pointer advances on NACK too, so the next read resumes after the last byte sent
                        addr_nxt = reg_addr + ADDR_ONE;
                        if (!sda) begin
                            rd_en_nxt   = 1'b1;
                            bit_cnt_nxt = 3'd2;
                        end else begin
                            bit_cnt_nxt = '0;
                            state_nxt   = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 3'd2) begin
                        sda_oe_nxt  = ~tx_sr[I2C_BYTE_W-1];
                        tx_nxt      = {tx_sr[I2C_BYTE_W-2:0], 1'b0};
                        bit_cnt_nxt = '0;
                        state_nxt   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
